fp_min_max_pipe: RTL and testbench

//  Two-stage pipelined IEEE-754 minNum/maxNum unit with valid/ready handshake on both sides.

---
 rtl/fp_minmax_pkg.sv | 26 ++
 rtl/fp_minmax_classify.sv | 26 ++
 rtl/max_expo_chk.sv | 11 +
 rtl/fp_min_max_pipe.sv | 130 +++++++++++++
 tb/tb_fp_min_max_pipe.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_minmax_pkg.sv
// Shared types and helpers for the pipelined floating-point minNum/maxNum unit.
package fp_minmax_pkg;

  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_zero;
  } fp_class_t;

  typedef enum logic {OP_MIN = 1'b0, OP_MAX = 1'b1} minmax_op_t;

  // Quiet NaN: sign 0, exponent all ones, mantissa MSB set, rest zero.
  function automatic logic [63:0] canon_qnan(input int expo_w, input int mant_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i >= mant_w - 1 && i < mant_w + expo_w) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic mag_lt(input logic [63:0] a, input logic [63:0] b);
    return a < b;
  endfunction

endpackage

// File: rtl/fp_minmax_classify.sv
// Per-operand classification: NaN, signalling NaN and zero detect.
module fp_minmax_classify
  import fp_minmax_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic [EXPO_W-1:0] expo_i,
  input  logic [MANT_W-1:0] mant_i,
  output fp_class_t         cls_o
);

  logic expo_max;
  logic mant_nz;

  max_expo_chk #(.EXPO_W(EXPO_W)) u_expo_chk (
    .expo_i    (expo_i),
    .all_ones_o(expo_max)
  );

  assign mant_nz        = |mant_i;
  assign cls_o.is_nan   = expo_max && mant_nz;
  assign cls_o.is_snan  = expo_max && mant_nz && !mant_i[MANT_W-1];
  assign cls_o.is_zero  = (expo_i == '0) && !mant_nz;

endmodule

// File: rtl/max_expo_chk.sv
// Flags an exponent field that is all ones (infinity or NaN encoding).
module max_expo_chk #(
  parameter int EXPO_W = 8
) (
  input  logic [EXPO_W-1:0] expo_i,
  output logic              all_ones_o
);

  assign all_ones_o = &expo_i;

endmodule

// File: rtl/fp_min_max_pipe.sv
// Two-stage minNum/maxNum pipeline: stage 1 classifies, stage 2 compares and selects.
module fp_min_max_pipe
  import fp_minmax_pkg::*;
#(
  parameter  int SIGN_W = 1,
  parameter  int EXPO_W = 8,
  parameter  int MANT_W = 23,
  localparam int FP_W   = SIGN_W + EXPO_W + MANT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_a,
  input  logic [FP_W-1:0] in_b,
  input  logic            in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_res,
  output logic            out_flag_nv,
  output logic            out_flag_nan
);

  localparam logic [FP_W-1:0] QNAN = FP_W'(canon_qnan(EXPO_W, MANT_W));

  if (SIGN_W != 1) begin : g_bad_sign
    $error("fp_min_max_pipe: SIGN_W must be 1");
  end

  fp_class_t  cls_a, cls_b;
  logic       s1_valid_q;
  logic [FP_W-1:0] s1_a_q, s1_b_q;
  fp_class_t  s1_cls_a_q, s1_cls_b_q;
  minmax_op_t s1_op_q;

  logic            out_valid_q, nv_q, nan_q;
  logic [FP_W-1:0] res_q;
  logic [FP_W-1:0] res_d;
  logic            nv_d, nan_d;
  logic            s1_adv, s2_adv;

  fp_minmax_classify #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls_a (
    .expo_i(in_a[FP_W-2:MANT_W]),
    .mant_i(in_a[MANT_W-1:0]),
    .cls_o (cls_a)
  );

  fp_minmax_classify #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls_b (
    .expo_i(in_b[FP_W-2:MANT_W]),
    .mant_i(in_b[MANT_W-1:0]),
    .cls_o (cls_b)
  );

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
        s1_op_q    <= minmax_op_t'(in_op);
        s1_cls_a_q <= cls_a;
        s1_cls_b_q <= cls_b;
      end
    end
  end

  always_comb begin
    logic sign_a, sign_b, a_lt_b, b_lt_a, both_zero;
    logic [FP_W-2:0] mag_a, mag_b;
    sign_a    = s1_a_q[FP_W-1];
    sign_b    = s1_b_q[FP_W-1];
    mag_a     = s1_a_q[FP_W-2:0];
    mag_b     = s1_b_q[FP_W-2:0];
    both_zero = s1_cls_a_q.is_zero && s1_cls_b_q.is_zero;
    a_lt_b    = 1'b0;
    b_lt_a    = 1'b0;
    if (sign_a != sign_b) begin
      // -0 < +0 falls out of this as well: the negative operand is smaller.
      a_lt_b = sign_a;
      b_lt_a = sign_b;
    end else if (!both_zero) begin
      a_lt_b = sign_a ? mag_lt(64'(mag_b), 64'(mag_a)) : mag_lt(64'(mag_a), 64'(mag_b));
      b_lt_a = sign_a ? mag_lt(64'(mag_a), 64'(mag_b)) : mag_lt(64'(mag_b), 64'(mag_a));
    end

    nv_d  = s1_cls_a_q.is_snan || s1_cls_b_q.is_snan;
    nan_d = 1'b0;
    res_d = s1_a_q;
    if (s1_cls_a_q.is_nan && s1_cls_b_q.is_nan) begin
      res_d = QNAN;
      nan_d = 1'b1;
    end else if (s1_cls_a_q.is_nan) begin
      res_d = s1_b_q;
    end else if (s1_cls_b_q.is_nan) begin
      res_d = s1_a_q;
    end else if (s1_op_q == OP_MIN) begin
      res_d = b_lt_a ? s1_b_q : s1_a_q;
    end else begin
      res_d = a_lt_b ? s1_b_q : s1_a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      nv_q        <= 1'b0;
      nan_q       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q <= res_d;
        nv_q  <= nv_d;
        nan_q <= nan_d;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_res      = res_q;
  assign out_flag_nv  = nv_q;
  assign out_flag_nan = nan_q;

endmodule

// File: tb/tb_fp_min_max_pipe.sv
// Self-checking bench: directed binary32 cases plus randomized traffic against an ordering-key model.
module tb_fp_min_max_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic        out_flag_nv;
  logic        out_flag_nan;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] exp_q[$];   // {nan, nv, res}

  fp_min_max_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res     (out_res),
    .out_flag_nv (out_flag_nv),
    .out_flag_nan(out_flag_nan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic bit m_is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction

  // Total order over non-NaN encodings; -0 maps just below +0.
  function automatic longint m_key(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m - 1 : m;
  endfunction

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic nv;
    logic [31:0] r;
    nv = (m_is_nan(a) && !a[22]) || (m_is_nan(b) && !b[22]);
    if (m_is_nan(a) && m_is_nan(b)) return {1'b1, nv, 32'h7FC0_0000};
    if (m_is_nan(a)) return {1'b0, nv, b};
    if (m_is_nan(b)) return {1'b0, nv, a};
    if (op) r = (m_key(b) > m_key(a)) ? b : a;
    else    r = (m_key(b) < m_key(a)) ? b : a;
    return {1'b0, nv, r};
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'({out_flag_nan, out_flag_nv, out_res}), 64'(prev_out));
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_op));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
        else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("res", 64'(out_res), 64'(e[31:0]));
          chk("nv", 64'(out_flag_nv), 64'(e[32]));
          chk("nan", 64'(out_flag_nan), 64'(e[33]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_flag_nan, out_flag_nv, out_res};
    end
  end

  // Presents a pair and returns just after the edge where it transferred.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op);
    int n;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] w_res, input logic w_nv, input logic w_nan);
    int n;
    drive(a, b, op);
    idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({tag, "_lat"}, 64'(n), 64'd2);
    chk({tag, "_res"}, 64'(out_res), 64'(w_res));
    chk({tag, "_nv"}, 64'(out_flag_nv), 64'(w_nv));
    chk({tag, "_nan"}, 64'(out_flag_nan), 64'(w_nan));
    wait_drain();
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    x = $urandom();
    case ($urandom_range(0, 9))
      0: x = {x[31], 8'hFF, 1'b1, x[21:0]};
      1: x = {x[31], 8'hFF, 1'b0, x[21:1], 1'b1};
      2: x = {x[31], 8'hFF, 23'd0};
      3: x = {x[31], 31'd0};
      4: x = {x[31], 8'h00, x[22:0]};
      5: x = {x[31], 8'h7F, 20'd0, x[2:0]};
      default: ;
    endcase
    return x;
  endfunction

  bit done = 1'b0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_res", 64'(out_res), 64'd0);
    chk("rst_flags", 64'({out_flag_nv, out_flag_nan}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    run_one("t1_min", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    run_one("t2_max_z", 32'h0000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    run_one("t2_min_z", 32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    run_one("t3_qnan", 32'h7FC0_0000, 32'h4040_0000, 1'b1, 32'h4040_0000, 1'b0, 1'b0);
    run_one("t3_snan", 32'h7F80_0001, 32'h4040_0000, 1'b1, 32'h4040_0000, 1'b1, 1'b0);
    run_one("t3_inf", 32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 1'b0, 1'b0);
    run_one("t4_2nan", 32'h7FC0_0001, 32'hFF80_0001, 1'b0, 32'h7FC0_0000, 1'b1, 1'b1);
    run_one("eq_a", 32'hC120_0000, 32'hC120_0000, 1'b0, 32'hC120_0000, 1'b0, 1'b0);
    run_one("neg_min", 32'hC000_0000, 32'hBF80_0000, 1'b0, 32'hC000_0000, 1'b0, 1'b0);
    run_one("neg_max", 32'hC000_0000, 32'hBF80_0000, 1'b1, 32'hBF80_0000, 1'b0, 1'b0);

    // Backpressure: 5 back-to-back pairs with the sink stalled for 4 cycles.
    fork
      begin
        for (int i = 0; i < 5; i++)
          drive(32'h3F80_0000 + 32'(i) * 32'h0080_0000, 32'h4100_0000, 1'b0);
        idle();
      end
      begin
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with two pairs in flight.
    out_ready = 1'b0;
    drive(32'h4000_0000, 32'h3F80_0000, 1'b1);
    drive(32'h4040_0000, 32'h3F80_0000, 1'b1);
    idle();
    @(negedge clk);
    chk("rst6_full", 64'({out_valid, in_ready}), 64'b10);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst6_out_valid", 64'(out_valid), 64'd0);
    chk("rst6_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst6_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random gaps and random backpressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [31:0] a, b;
          a = rand_fp();
          case ($urandom_range(0, 7))
            0: b = a;
            1: b = a ^ 32'h8000_0000;
            default: b = rand_fp();
          endcase
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
          drive(a, b, 1'($urandom_range(0, 1)));
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
